// File: rtl/fpu_writeback_buffer_if.sv
// Bundle between the issue/FPU/integer side and the writeback buffer.
// Covers the write requests, the forwarding lookup and the status and writeback outputs.
interface fpu_writeback_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              fpu_enable;
  logic [4:0]        fpu_addr;
  logic [DATA_W-1:0] fpu_data;
  logic              fpu_float;
  logic              int_enable;
  logic [4:0]        int_addr;
  logic [DATA_W-1:0] int_data;
  logic [4:0]        fwd_addr;
  logic              fwd_float;
  logic              wr_enable;
  logic              wr_float;
  logic [4:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              almost_full;
  logic              overflow;
  logic [CNT_W-1:0]  count;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  modport master (
    output fpu_enable, fpu_addr, fpu_data, fpu_float,
    output int_enable, int_addr, int_data,
    output fwd_addr, fwd_float,
    input  wr_enable, wr_float, wr_addr, wr_data,
    input  almost_full, overflow, count, fwd_hit, fwd_data
  );

  modport slave (
    input  fpu_enable, fpu_addr, fpu_data, fpu_float,
    input  int_enable, int_addr, int_data,
    input  fwd_addr, fwd_float,
    output wr_enable, wr_float, wr_addr, wr_data,
    output almost_full, overflow, count, fwd_hit, fwd_data
  );
endinterface

// File: rtl/fpu_writeback_buffer.sv
// Queues FPU results behind integer-unit writes to a shared register-file write port,
// with bypass when idle, a sticky overflow flag and youngest-match forwarding.
module fpu_writeback_buffer #(
  parameter int DEPTH  = 4,
  parameter int AFULL  = DEPTH - 1,
  parameter int DATA_W = 32
) (
  input logic                   clk,
  input logic                   reset,
  fpu_writeback_buffer_if.slave wb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_data  [DEPTH];
  logic [4:0]        mem_addr  [DEPTH];
  logic              mem_float [DEPTH];

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;

  logic              wr_enable_p1;
  logic              wr_float_p1;
  logic [4:0]        wr_addr_p1;
  logic [DATA_W-1:0] wr_data_p1;

  logic              empty, full, pop, bypass, push_req, push_ok, drop;
  logic              sel_valid, sel_float;
  logic [4:0]        sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              fwd_hit_c;
  logic [DATA_W-1:0] fwd_data_c;
  logic [PTR_W-1:0]  fwd_idx;

  // Integer register x0 is hardwired to zero, so writes to it are dropped.
  function automatic logic writable(input logic is_float, input logic [4:0] addr);
    return is_float || (addr != 5'd0);
  endfunction

  // Stage 0: write-port arbitration and FIFO push/pop decisions
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CNT_W'(DEPTH));
    pop       = !wb.int_enable && !empty;
    bypass    = !wb.int_enable && empty && wb.fpu_enable;
    push_req  = wb.fpu_enable && !bypass;
    push_ok   = push_req && (!full || pop);
    drop      = push_req && full && !pop;
    sel_valid = 1'b0;
    sel_float = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    if (wb.int_enable) begin
      sel_valid = 1'b1;
      sel_addr  = wb.int_addr;
      sel_data  = wb.int_data;
    end else if (pop) begin
      sel_valid = 1'b1;
      sel_float = mem_float[rd_ptr];
      sel_addr  = mem_addr[rd_ptr];
      sel_data  = mem_data[rd_ptr];
    end else if (bypass) begin
      sel_valid = 1'b1;
      sel_float = wb.fpu_float;
      sel_addr  = wb.fpu_addr;
      sel_data  = wb.fpu_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  // A full FIFO that pops on the same edge reuses the head slot, which was read this cycle.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data[wr_ptr]  <= wb.fpu_data;
      mem_addr[wr_ptr]  <= wb.fpu_addr;
      mem_float[wr_ptr] <= wb.fpu_float;
    end
  end

  // Stage 1: registered register-file write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_enable_p1 <= 1'b0;
      wr_float_p1  <= 1'b0;
      wr_addr_p1   <= '0;
      wr_data_p1   <= '0;
    end else begin
      wr_enable_p1 <= sel_valid && writable(sel_float, sel_addr);
      if (sel_valid) begin
        wr_float_p1 <= sel_float;
        wr_addr_p1  <= sel_addr;
        wr_data_p1  <= sel_data;
      end
    end
  end

  // Walk from oldest to youngest so later matches override; wr_* is older than every entry.
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    fwd_idx    = '0;
    if (wr_enable_p1 && (wr_float_p1 == wb.fwd_float) && (wr_addr_p1 == wb.fwd_addr)) begin
      fwd_hit_c  = 1'b1;
      fwd_data_c = wr_data_p1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (mem_float[fwd_idx] == wb.fwd_float) &&
          (mem_addr[fwd_idx] == wb.fwd_addr)) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = mem_data[fwd_idx];
      end
    end
  end

  assign wb.wr_enable   = wr_enable_p1;
  assign wb.wr_float    = wr_float_p1;
  assign wb.wr_addr     = wr_addr_p1;
  assign wb.wr_data     = wr_data_p1;
  assign wb.count       = count_q;
  assign wb.overflow    = overflow_q;
  assign wb.almost_full = (count_q >= CNT_W'(AFULL));
  assign wb.fwd_hit     = fwd_hit_c;
  assign wb.fwd_data    = fwd_data_c;
endmodule

// File: tb/tb_fpu_writeback_buffer.sv
// Directed bench for fpu_writeback_buffer: a vector table for single-edge behaviour,
// then hand-written sequences for fill/overflow, forwarding and mid-run reset.
module tb_fpu_writeback_buffer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  int   npass = 0;
  int   ntot  = 0;

  fpu_writeback_buffer_if #(.DEPTH(DEPTH)) bus ();

  fpu_writeback_buffer #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .wb   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ie; logic [4:0] ia; logic [31:0] id;
    logic        fe; logic ff; logic [4:0] fa; logic [31:0] fd;
    logic        we; logic wf; logic [4:0] wa; logic [31:0] wd;
    int          cnt; logic af; logic ov;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic ie, input logic [4:0] ia, input logic [31:0] id,
                              input logic fe, input logic ff, input logic [4:0] fa,
                              input logic [31:0] fd, input logic we, input logic wf,
                              input logic [4:0] wa, input logic [31:0] wd, input int cnt,
                              input logic af, input logic ov);
    vec_t v;
    v.ie = ie; v.ia = ia; v.id = id; v.fe = fe; v.ff = ff; v.fa = fa; v.fd = fd;
    v.we = we; v.wf = wf; v.wa = wa; v.wd = wd; v.cnt = cnt; v.af = af; v.ov = ov;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic check_wr(input string nm, input logic we, input logic wf,
                          input logic [4:0] wa, input logic [31:0] wd);
    chk({nm, ".wr_enable"}, 32'(bus.wr_enable), 32'(we));
    if (we) begin
      chk({nm, ".wr_float"}, 32'(bus.wr_float), 32'(wf));
      chk({nm, ".wr_addr"},  32'(bus.wr_addr),  32'(wa));
      chk({nm, ".wr_data"},  bus.wr_data,       wd);
    end
  endtask

  task automatic check_state(input string nm, input int cnt, input logic af, input logic ov);
    chk({nm, ".count"},       32'(bus.count),       32'(cnt));
    chk({nm, ".almost_full"}, 32'(bus.almost_full), 32'(af));
    chk({nm, ".overflow"},    32'(bus.overflow),    32'(ov));
  endtask

  task automatic check_fwd(input string nm, input logic f, input logic [4:0] a,
                           input logic hit, input logic [31:0] d);
    bus.fwd_float = f;
    bus.fwd_addr  = a;
    #1;
    chk({nm, ".fwd_hit"},  32'(bus.fwd_hit), 32'(hit));
    chk({nm, ".fwd_data"}, bus.fwd_data,     d);
  endtask

  task automatic set_in(input logic ie, input logic [4:0] ia, input logic [31:0] id,
                        input logic fe, input logic ff, input logic [4:0] fa,
                        input logic [31:0] fd);
    bus.int_enable = ie; bus.int_addr = ia; bus.int_data = id;
    bus.fpu_enable = fe; bus.fpu_float = ff; bus.fpu_addr = fa; bus.fpu_data = fd;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Bypass, int priority with queueing, x0 suppression, push+pop, integer-file FPU result.
    tbl.push_back(mk(0,0,0,          0,0,0,0,             0,0,0,0,             0,0,0));
    tbl.push_back(mk(0,0,0,          1,1,2,32'h41600000,  1,1,2,32'h41600000,  0,0,0));
    tbl.push_back(mk(1,3,5,          1,1,2,1,             1,0,3,5,             1,0,0));
    tbl.push_back(mk(1,3,5,          1,1,3,2,             1,0,3,5,             2,0,0));
    tbl.push_back(mk(1,3,5,          1,1,4,3,             1,0,3,5,             3,1,0));
    tbl.push_back(mk(0,0,0,          0,0,0,0,             1,1,2,1,             2,0,0));
    tbl.push_back(mk(0,0,0,          0,0,0,0,             1,1,3,2,             1,0,0));
    tbl.push_back(mk(0,0,0,          0,0,0,0,             1,1,4,3,             0,0,0));
    tbl.push_back(mk(0,0,0,          0,0,0,0,             0,0,0,0,             0,0,0));
    tbl.push_back(mk(1,0,7,          0,0,0,0,             0,0,0,0,             0,0,0));
    tbl.push_back(mk(0,0,0,          1,0,0,9,             0,0,0,0,             0,0,0));
    tbl.push_back(mk(1,1,32'h11,     1,0,0,9,             1,0,1,32'h11,        1,0,0));
    tbl.push_back(mk(0,0,0,          0,0,0,0,             0,0,0,0,             0,0,0));
    tbl.push_back(mk(0,0,0,          0,0,0,0,             0,0,0,0,             0,0,0));
    tbl.push_back(mk(1,4,32'h44,     1,1,6,32'h60,        1,0,4,32'h44,        1,0,0));
    tbl.push_back(mk(0,0,0,          1,1,7,32'h70,        1,1,6,32'h60,        1,0,0));
    tbl.push_back(mk(0,0,0,          0,0,0,0,             1,1,7,32'h70,        0,0,0));
    tbl.push_back(mk(0,0,0,          1,0,9,32'h99,        1,0,9,32'h99,        0,0,0));

    reset = 1'b0;
    idle();
    bus.fwd_float = 1'b0;
    bus.fwd_addr  = 5'd0;
    #12;
    chk("reset.wr_enable", 32'(bus.wr_enable), 32'd0);
    chk("reset.wr_addr",   32'(bus.wr_addr),   32'd0);
    chk("reset.wr_data",   bus.wr_data,        32'd0);
    check_state("reset", 0, 1'b0, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].ie, tbl[i].ia, tbl[i].id, tbl[i].fe, tbl[i].ff, tbl[i].fa, tbl[i].fd);
      tick();
      check_wr($sformatf("vec%0d", i), tbl[i].we, tbl[i].wf, tbl[i].wa, tbl[i].wd);
      check_state($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].af, tbl[i].ov);
    end

    // Fill to DEPTH behind int writes, then push into a full FIFO while it pops.
    for (int k = 0; k < 4; k++) begin
      set_in(1, 3, 5, 1, 1, 5'(16 + k), 32'hB0 + k);
      tick();
      check_state($sformatf("fill%0d", k), k + 1, (k + 1) >= 3, 1'b0);
    end
    set_in(0, 0, 0, 1, 1, 5'd20, 32'hB4);
    tick();
    check_wr("fullpop", 1, 1, 5'd16, 32'hB0);
    check_state("fullpop", 4, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      idle();
      tick();
      check_wr($sformatf("drainB%0d", k), 1, 1, 5'(17 + k), 32'hB1 + k);
      chk($sformatf("drainB%0d.count", k), 32'(bus.count), 32'(3 - k));
    end

    // Five results while int writes hold the port: the fifth is lost.
    for (int k = 0; k < 5; k++) begin
      set_in(1, 3, 5, 1, 1, 5'(10 + k), 32'hA0 + k);
      tick();
      check_state($sformatf("ovf%0d", k), (k < 4) ? k + 1 : 4, (k >= 2), (k == 4));
    end
    for (int k = 0; k < 4; k++) begin
      idle();
      tick();
      check_wr($sformatf("drainA%0d", k), 1, 1, 5'(10 + k), 32'hA0 + k);
      check_state($sformatf("drainA%0d", k), 3 - k, (3 - k) >= 3, 1'b1);
    end
    idle();
    tick();
    check_wr("drainA_end", 0, 0, 0, 0);
    check_state("drainA_end", 0, 1'b0, 1'b1);

    // Forwarding: two pending f5 values, then FIFO entry versus wr_* register.
    set_in(1, 3, 5, 1, 1, 5'd5, 32'hAAAA);
    tick();
    set_in(1, 3, 5, 1, 1, 5'd5, 32'hBBBB);
    tick();
    idle();
    check_fwd("fwd_f5",  1'b1, 5'd5, 1'b1, 32'hBBBB);
    check_fwd("fwd_x5",  1'b0, 5'd5, 1'b0, 32'd0);
    check_fwd("fwd_x3",  1'b0, 5'd3, 1'b1, 32'd5);
    tick();
    tick();
    set_in(1, 3, 5, 1, 1, 5'd5, 32'hCCCC);
    tick();
    set_in(0, 0, 0, 1, 1, 5'd5, 32'hDDDD);
    tick();
    idle();
    check_wr("fwd_young", 1, 1, 5'd5, 32'hCCCC);
    check_fwd("fwd_young", 1'b1, 5'd5, 1'b1, 32'hDDDD);
    tick();
    check_fwd("fwd_wronly", 1'b1, 5'd5, 1'b1, 32'hDDDD);
    tick();
    check_fwd("fwd_none", 1'b1, 5'd5, 1'b0, 32'd0);

    // Asynchronous reset with three results queued.
    for (int k = 0; k < 3; k++) begin
      set_in(1, 3, 5, 1, 1, 5'(k + 1), 32'h100 + k);
      tick();
    end
    check_state("prerst", 3, 1'b1, 1'b1);
    idle();
    reset = 1'b0;
    #1;
    chk("midrst.wr_enable", 32'(bus.wr_enable), 32'd0);
    chk("midrst.wr_float",  32'(bus.wr_float),  32'd0);
    chk("midrst.wr_addr",   32'(bus.wr_addr),   32'd0);
    chk("midrst.wr_data",   bus.wr_data,        32'd0);
    check_state("midrst", 0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_wr($sformatf("postrst%0d", k), 0, 0, 0, 0);
      chk($sformatf("postrst%0d.count", k), 32'(bus.count), 32'd0);
    end
    set_in(0, 0, 0, 1, 1, 5'd8, 32'h1234);
    tick();
    check_wr("postrst_bypass", 1, 1, 5'd8, 32'h1234);
    check_state("postrst_bypass", 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
